// File: rtl/sipo_frame.sv
// Serial-in/parallel-out word assembler with frame resync and a valid/ready
// holding register; dropped words raise a sticky overrun flag.
module sipo_frame #(
  parameter int unsigned WIDTH     = 16,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             data_in,
  input  logic             frame_start,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] sh, sh_nxt, sh_shift;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] data_out_nxt;
  logic             out_valid_nxt;
  logic             overrun_nxt;
  logic             word_done;
  logic             out_free;
  logic             xfer;

  // Shift direction fixed at elaboration
  generate
    if (MSB_FIRST) begin : g_msb
      assign sh_shift = {sh[WIDTH-2:0], data_in};
    end else begin : g_lsb
      assign sh_shift = {data_in, sh[WIDTH-1:1]};
    end
  endgenerate

  // frame_start wins over completion: a restarted word never emits
  assign word_done = in_valid & ~frame_start & (cnt == CNT_LAST);
  assign out_free  = ~out_valid | out_ready;
  assign xfer      = out_valid & out_ready;
  assign busy      = (cnt != '0);

  // Next-state logic for shifter, counter and holding register
  always_comb begin
    sh_nxt        = sh;
    cnt_nxt       = cnt;
    data_out_nxt  = data_out;
    out_valid_nxt = out_valid;
    overrun_nxt   = overrun;

    if (in_valid) begin
      sh_nxt = sh_shift;
      if (frame_start) begin
        cnt_nxt = CNT_ONE;
      end else if (word_done) begin
        cnt_nxt = '0;
      end else begin
        cnt_nxt = cnt + CNT_ONE;
      end
    end

    if (word_done) begin
      if (out_free) begin
        data_out_nxt  = sh_shift;
        out_valid_nxt = 1'b1;
      end else begin
        overrun_nxt = 1'b1;
      end
    end else if (xfer) begin
      out_valid_nxt = 1'b0;
    end
  end

  // State register; clr outranks every other synchronous event
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh        <= '0;
      cnt       <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (clr) begin
      sh        <= '0;
      cnt       <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sh        <= sh_nxt;
      cnt       <= cnt_nxt;
      data_out  <= data_out_nxt;
      out_valid <= out_valid_nxt;
      overrun   <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_sipo_frame.sv
// Bench for sipo_frame: one MSB-first and one LSB-first instance share stimulus
// and are compared against a bit-queue reference model.
module tb_sipo_frame;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst;
  logic         clr;
  logic         in_valid;
  logic         data_in;
  logic         frame_start;
  logic         out_ready;
  logic [W-1:0] data_m, data_l;
  logic         valid_m, valid_l;
  logic         busy_m, busy_l;
  logic         ovr_m, ovr_l;

  sipo_frame #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .data_in(data_in),
    .frame_start(frame_start), .out_ready(out_ready), .data_out(data_m),
    .out_valid(valid_m), .busy(busy_m), .overrun(ovr_m)
  );

  sipo_frame #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .data_in(data_in),
    .frame_start(frame_start), .out_ready(out_ready), .data_out(data_l),
    .out_valid(valid_l), .busy(busy_l), .overrun(ovr_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: received bits of the current partial word, plus the
  // holding register of each instance
  int           mq[$];
  logic [W-1:0] md_m, md_l;
  logic         mv_m, mv_l, mo_m, mo_l;

  // Output log of the MSB-first instance: cycle number and word while valid
  int           log_cyc[$];
  logic [W-1:0] log_dat[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < int'(W); i++) r[i] = x[W-1-i];
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    md_m = '0; md_l = '0;
    mv_m = 1'b0; mv_l = 1'b0;
    mo_m = 1'b0; mo_l = 1'b0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs
  task automatic model_step();
    logic         done;
    logic [W-1:0] wm, wl;
    logic         xm, xl;
    done = 1'b0; wm = '0; wl = '0;
    if (clr) begin
      model_reset();
    end else begin
      xm = mv_m & out_ready;
      xl = mv_l & out_ready;
      if (in_valid) begin
        if (frame_start) begin
          mq.delete();
          mq.push_back(int'(data_in));
        end else begin
          mq.push_back(int'(data_in));
          if (mq.size() == int'(W)) begin
            done = 1'b1;
            for (int i = 0; i < int'(W); i++) begin
              wm = wm | (W'(mq[i]) << (int'(W) - 1 - i));
              wl = wl | (W'(mq[i]) << i);
            end
            mq.delete();
          end
        end
      end
      if (done) begin
        if (!mv_m || out_ready) begin md_m = wm; mv_m = 1'b1; end else mo_m = 1'b1;
        if (!mv_l || out_ready) begin md_l = wl; mv_l = 1'b1; end else mo_l = 1'b1;
      end else begin
        if (xm) mv_m = 1'b0;
        if (xl) mv_l = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    check("m_data",  32'(data_m),  32'(md_m));
    check("m_valid", 32'(valid_m), 32'(mv_m));
    check("m_busy",  32'(busy_m),  32'(mq.size() != 0));
    check("m_ovr",   32'(ovr_m),   32'(mo_m));
    check("l_data",  32'(data_l),  32'(md_l));
    check("l_valid", 32'(valid_l), 32'(mv_l));
    check("l_busy",  32'(busy_l),  32'(mq.size() != 0));
    check("l_ovr",   32'(ovr_l),   32'(mo_l));
  endtask

  // One clock: model steps with the driven inputs, DUT sampled 1 after the edge
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    if (valid_m) begin
      log_cyc.push_back(cyc);
      log_dat.push_back(data_m);
    end
    compare_all();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; frame_start = 1'b0; data_in = 1'b0; clr = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Send a word serially; msb_order picks which end goes first on the wire
  task automatic send_word(input logic [W-1:0] w, input bit msb_order,
                           input int gap_min, input int gap_max,
                           input bit fs_first, input bit chk_busy);
    for (int i = 0; i < int'(W); i++) begin
      in_valid    = 1'b1;
      data_in     = msb_order ? w[W-1-i] : w[i];
      frame_start = fs_first && (i == 0);
      cycle();
      frame_start = 1'b0;
      if (chk_busy && i != int'(W) - 1) check("t2_busy_bit", 32'(busy_l), 32'd1);
      if (gap_max > 0 && i != int'(W) - 1) begin
        int g;
        g = int'($urandom_range(gap_max, gap_min));
        in_valid = 1'b0;
        for (int k = 0; k < g; k++) begin
          cycle();
          if (chk_busy) check("t2_busy_gap", 32'(busy_l), 32'd1);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] word;
    logic         rdy;
    logic         exp_valid;
    logic [W-1:0] exp_data;
    logic         exp_ovr;
  } vec_t;

  vec_t tbl[4];

  initial begin
    // Sequential word table: the third word is sent into a blocked register
    tbl[0] = '{word: 16'h3C5A, rdy: 1'b1, exp_valid: 1'b1, exp_data: 16'h3C5A, exp_ovr: 1'b0};
    tbl[1] = '{word: 16'h1234, rdy: 1'b1, exp_valid: 1'b1, exp_data: 16'h1234, exp_ovr: 1'b0};
    tbl[2] = '{word: 16'hBEEF, rdy: 1'b0, exp_valid: 1'b1, exp_data: 16'h1234, exp_ovr: 1'b1};
    tbl[3] = '{word: 16'h5A5A, rdy: 1'b1, exp_valid: 1'b1, exp_data: 16'h5A5A, exp_ovr: 1'b1};

    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; data_in = 1'b0;
    frame_start = 1'b0; out_ready = 1'b0;
    model_reset();
    #12;
    check("rst_data",  32'(data_m),  32'd0);
    check("rst_valid", 32'(valid_m), 32'd0);
    check("rst_busy",  32'(busy_m),  32'd0);
    check("rst_ovr",   32'(ovr_m),   32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // MSB-first word, valid for exactly one cycle
    out_ready = 1'b1;
    send_word(16'hA5C3, 1'b1, 0, 0, 1'b0, 1'b0);
    check("t1_valid", 32'(valid_m), 32'd1);
    check("t1_data",  32'(data_m),  32'hA5C3);
    idle(1);
    check("t1_valid_drop", 32'(valid_m), 32'd0);
    check("t1_data_hold",  32'(data_m),  32'hA5C3);

    // Table-driven words
    for (int v = 0; v < 4; v++) begin
      out_ready = tbl[v].rdy;
      send_word(tbl[v].word, 1'b1, 0, 0, 1'b0, 1'b0);
      check($sformatf("tbl%0d_valid", v), 32'(valid_m), 32'(tbl[v].exp_valid));
      check($sformatf("tbl%0d_data", v),  32'(data_m),  32'(tbl[v].exp_data));
      check($sformatf("tbl%0d_ldata", v), 32'(data_l),  32'(rev(tbl[v].exp_data)));
      check($sformatf("tbl%0d_ovr", v),   32'(ovr_m),   32'(tbl[v].exp_ovr));
    end

    // Backpressure: two words into a blocked register, then one transfer
    clr = 1'b1; cycle(); clr = 1'b0;
    out_ready = 1'b0;
    send_word(16'h1234, 1'b1, 0, 0, 1'b0, 1'b0);
    send_word(16'hBEEF, 1'b1, 0, 0, 1'b0, 1'b0);
    check("t3_data_held", 32'(data_m), 32'h1234);
    check("t3_ovr",       32'(ovr_m),  32'd1);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    check("t3_valid_after", 32'(valid_m), 32'd0);
    check("t3_data_after",  32'(data_m),  32'h1234);
    check("t3_ovr_sticky",  32'(ovr_m),   32'd1);
    clr = 1'b1; cycle(); clr = 1'b0;
    check("t3_ovr_clr", 32'(ovr_m), 32'd0);

    // LSB-first with random gaps between bits
    out_ready = 1'b1;
    send_word(16'hA5C3, 1'b0, 1, 3, 1'b0, 1'b1);
    check("t2_data", 32'(data_l), 32'hA5C3);
    idle(1);

    // Junk partial word discarded by frame_start
    log_cyc.delete(); log_dat.delete();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; data_in = 1'($urandom); cycle();
    end
    send_word(16'h8001, 1'b1, 0, 0, 1'b1, 1'b0);
    idle(2);
    check("t4_words", 32'(log_dat.size()), 32'd1);
    if (log_dat.size() > 0) check("t4_data", 32'(log_dat[0]), 32'h8001);
    check("t4_ovr", 32'(ovr_m), 32'd0);

    // Back-to-back words land at edges 16, 32, 48
    log_cyc.delete(); log_dat.delete();
    begin
      int c0;
      logic [W-1:0] exp_w[3];
      exp_w[0] = 16'h00FF; exp_w[1] = 16'hFF00; exp_w[2] = 16'h5A5A;
      c0 = cyc;
      for (int k = 0; k < 3; k++) send_word(exp_w[k], 1'b1, 0, 0, 1'b0, 1'b0);
      idle(2);
      check("t5_words", 32'(log_dat.size()), 32'd3);
      for (int k = 0; k < 3 && k < log_dat.size(); k++) begin
        check($sformatf("t5_edge%0d", k), 32'(log_cyc[k] - c0), 32'(16 * (k + 1)));
        check($sformatf("t5_data%0d", k), 32'(log_dat[k]), 32'(exp_w[k]));
      end
      check("t5_ovr", 32'(ovr_m), 32'd0);
    end

    // Asynchronous reset in the middle of a word
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; data_in = 1'(i & 1); cycle();
    end
    in_valid = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    check("t6_data",  32'(data_m),  32'd0);
    check("t6_valid", 32'(valid_m), 32'd0);
    check("t6_busy",  32'(busy_m),  32'd0);
    check("t6_ovr",   32'(ovr_m),   32'd0);
    check("t6_lbusy", 32'(busy_l),  32'd0);
    model_reset();
    #2;
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    send_word(16'h0F0F, 1'b1, 0, 0, 1'b0, 1'b0);
    check("t6_word",  32'(data_m), 32'h0F0F);
    check("t6_lword", 32'(data_l), 32'hF0F0);
    check("t6_ovr2",  32'(ovr_m),  32'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      in_valid    = ($urandom_range(3, 0) != 0);
      data_in     = 1'($urandom);
      frame_start = ($urandom_range(31, 0) == 0);
      out_ready   = 1'($urandom);
      clr         = ($urandom_range(199, 0) == 0);
      cycle();
    end
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sipo_frame.md
# sipo_frame

Parametrised serial-in/parallel-out word assembler with a bit-valid strobe, frame resynchronisation, and a valid/ready output holding register. It collects serial operand bits from the bit-serial front end into WIDTH-bit words and hands them to the multiplier datapath. Shift order is selectable. Backpressure is handled without corrupting the held word, and lost words are flagged with a sticky overrun.

## Interface
Parameters:
- WIDTH, 16, word width in bits; legal range ≥ 2.
- MSB_FIRST, 1, 1 = first received bit lands in data_out[WIDTH-1]; 0 = first received bit lands in data_out[0].

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- clr  input  1  synchronous clear of all state; highest synchronous priority.
- in_valid  input  1  data_in carries a valid bit this cycle.
- data_in  input  1  serial data bit.
- frame_start  input  1  qualified by in_valid; the current bit is bit 0 of a new word.
- out_ready  input  1  consumer accepts data_out this cycle.
- data_out  output  WIDTH  assembled word from the holding register.
- out_valid  output  1  data_out holds an unconsumed word.
- busy  output  1  partial word in progress (cnt != 0).
- overrun  output  1  sticky flag: a completed word was dropped.

## Operation
- Internal state:
  - shift register sh[WIDTH-1:0].
  - bit counter cnt, range 0..WIDTH-1, width $clog2(WIDTH).
- Shift rule, applied on a bit accept (in_valid=1):
  - MSB_FIRST=1: sh <= {sh[WIDTH-2:0], data_in}.
  - MSB_FIRST=0: sh <= {data_in, sh[WIDTH-1:1]}.
- Counter rule:
  - in_valid=1 & frame_start=1: the bit is shifted in and cnt <= 1. Any prior partial word is discarded; it is not flagged as overrun.
  - in_valid=1 & cnt==WIDTH-1 & frame_start=0: word complete; cnt <= 0.
  - Otherwise, on in_valid=1: cnt <= cnt+1.
  - in_valid=0: sh and cnt hold; frame_start is ignored.
- Completed word: W = the shift result that includes the final bit.
  - Output register free, i.e. out_valid=0, or out_valid=1 & out_ready=1 at the same edge: data_out <= W and out_valid <= 1.
  - Output register blocked (out_valid=1 & out_ready=0): W is dropped, data_out is unchanged, and overrun <= 1.
- Handshake: a transfer occurs at an edge where out_valid & out_ready. After a transfer with no simultaneous completion, out_valid <= 0 and data_out holds its last value. data_out is stable while out_valid=1 & out_ready=0.
- overrun stays set until rst or clr.
- clr=1: sh, cnt, data_out, out_valid and overrun all go to 0. All other inputs are ignored that cycle.
- Combinational output: busy = (cnt != 0).
- With WIDTH=4, MSB_FIRST=1, in_valid tied high, frame_start=0 and out_ready=1, the shift path matches the legacy 4-bit SIPO. data_out updates once per 4 bits rather than every bit.

## Timing
- Reset (rst low, asynchronous): sh=0, cnt=0, data_out=0, out_valid=0, busy=0, overrun=0, all immediately. The first edge after rst deasserts behaves as cycle 0 of an empty block.
- Reset mid-word: the partial word is lost and no overrun is raised.
- Latency: if the final bit is sampled at edge N, out_valid=1 and data_out=W are visible after edge N. That is one cycle, with no extra pipeline stage.
- Throughput: one bit per clk. One word per WIDTH cycles with continuous in_valid and out_ready=1. out_valid may stay high across back-to-back words.
- Simultaneous events at one edge:
  - clr overrides frame_start, completion and transfer.
  - Completion with transfer gives a handoff: the new word is loaded and there is no overrun.
  - frame_start overrides completion: the word restarts and nothing is emitted.
- out_ready has no effect while out_valid=0.

## Test plan
1. MSB_FIRST=1, WIDTH=16, out_ready=1; shift 0xA5C3 MSB-first on 16 consecutive cycles. Required: out_valid=1 and data_out=0xA5C3 one edge after the 16th bit; out_valid high for exactly 1 cycle.
2. MSB_FIRST=0, WIDTH=16; shift 0xA5C3 LSB-first, with in_valid low for 1–3 random cycles between bits. Required: data_out=0xA5C3; busy=1 throughout; cnt holds during gaps.
3. out_ready=0; send 0x1234 then 0xBEEF. Required: data_out stays 0x1234 and overrun=1 after the 32nd bit. Then raise out_ready for 1 cycle: out_valid=0 next cycle, data_out=0x1234, overrun still 1. Then clr: overrun=0.
4. Send 5 bits of junk, then 0x8001 with frame_start on its first bit. Required: exactly one word, data_out=0x8001, overrun=0.
5. Back-to-back 0x00FF, 0xFF00, 0x5A5A with out_ready=1 and continuous in_valid. Required: three words at edges 16, 32 and 48, in order, no overrun.
6. Assert rst low asynchronously mid-cycle after 8 bits, release, then send 0x0F0F. Required: all outputs 0 immediately on assertion; the next word is 0x0F0F with no residue.
